parking_exit_controller: RTL

PARKING_EXIT_CONTROLLER -- requirements
Module: parking_exit_controller

---
 rtl/parking_exit_controller_pkg.sv | 81 ++++++++
 rtl/parking_exit_controller_if.sv | 31 +++
 rtl/parking_occupancy_counter.sv | 33 +++
 rtl/parking_exit_controller.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/parking_exit_controller_pkg.sv
// Shared definitions for the parking exit controller: state encodings,
// seven-segment glyphs, default exit code and the per-state panel decode.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_PASS  = 3'd1,
        ST_WRONG_PASS = 3'd2,
        ST_OPEN       = 3'd3,
        ST_BLOCKED    = 3'd4,
        ST_LOCKED     = 3'd5
    } state_t;

    // Active-low glyphs, bit 6 = segment g
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_G     = 7'b0000010;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_L     = 7'b1000111;

    localparam logic [1:0] DEFAULT_EXIT_CODE_1 = 2'b10;
    localparam logic [1:0] DEFAULT_EXIT_CODE_2 = 2'b01;
    localparam int         DEFAULT_CAPACITY    = 8;
    localparam int         DEFAULT_WAIT_CYCLES = 4;
    localparam int         DEFAULT_MAX_TRIES   = 3;

    typedef struct packed {
        logic       gate_open;
        logic       green_led;
        logic       red_led;
        logic [6:0] hex_1;
        logic [6:0] hex_2;
    } panel_t;

    function automatic logic blinks_in(input state_t st);
        return (st == ST_WRONG_PASS) || (st == ST_BLOCKED) || (st == ST_LOCKED);
    endfunction

    function automatic panel_t decode_panel(input state_t st, input logic blink);
        panel_t p;
        p.gate_open = 1'b0;
        p.green_led = 1'b0;
        p.red_led   = 1'b1;
        p.hex_1     = SEG_BLANK;
        p.hex_2     = SEG_BLANK;
        case (st)
            ST_WAIT_PASS: begin
                p.hex_1 = SEG_E;
                p.hex_2 = SEG_N;
            end
            ST_WRONG_PASS: begin
                p.red_led = blink;
                p.hex_1   = SEG_E;
                p.hex_2   = SEG_E;
            end
            ST_OPEN: begin
                p.gate_open = 1'b1;
                p.green_led = 1'b1;
                p.red_led   = 1'b0;
                p.hex_1     = SEG_G;
                p.hex_2     = SEG_O;
            end
            ST_BLOCKED: begin
                p.red_led = blink;
                p.hex_1   = SEG_S;
                p.hex_2   = SEG_P;
            end
            ST_LOCKED: begin
                p.red_led = blink;
                p.hex_1   = SEG_L;
                p.hex_2   = SEG_L;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/parking_exit_controller_if.sv
// Exit-lane signal bundle: gate/sensor/keypad inputs and lamp/display/occupancy outputs.
interface parking_exit_controller_if;

    logic       car_entered;
    logic       sensor_exit_approach;
    logic       sensor_exit_clear;
    logic [1:0] pass_1;
    logic [1:0] pass_2;
    logic       supervisor_clear;

    logic       gate_open;
    logic       green_led;
    logic       red_led;
    logic [6:0] hex_1;
    logic [6:0] hex_2;
    logic [7:0] car_count;
    logic       full;

    modport master (
        output car_entered, sensor_exit_approach, sensor_exit_clear,
        output pass_1, pass_2, supervisor_clear,
        input  gate_open, green_led, red_led, hex_1, hex_2, car_count, full
    );

    modport slave (
        input  car_entered, sensor_exit_approach, sensor_exit_clear,
        input  pass_1, pass_2, supervisor_clear,
        output gate_open, green_led, red_led, hex_1, hex_2, car_count, full
    );

endinterface

// File: rtl/parking_occupancy_counter.sv
// Lot occupancy counter: saturating increment on entry, saturating decrement on exit.
module parking_occupancy_counter #(
    parameter int CAPACITY = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] car_count,
    output logic       full
);

    localparam logic [7:0] CAP = 8'(CAPACITY);

    logic [7:0] count_reg;

    // An entry and an exit in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 8'd0;
        end else if (inc && !dec) begin
            if (count_reg != CAP)
                count_reg <= count_reg + 8'd1;
        end else if (dec && !inc) begin
            if (count_reg != 8'd0)
                count_reg <= count_reg - 8'd1;
        end
    end

    assign car_count = count_reg;
    assign full      = (count_reg == CAP);

endmodule

// File: rtl/parking_exit_controller.sv
// Exit barrier controller: code entry with retry/lockout, tailgate blocking,
// Moore lamp/display outputs and occupancy tracking.
module parking_exit_controller
    import parking_pkg::*;
#(
    parameter int         CAPACITY    = DEFAULT_CAPACITY,
    parameter int         WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter logic [1:0] EXIT_CODE_1 = DEFAULT_EXIT_CODE_1,
    parameter logic [1:0] EXIT_CODE_2 = DEFAULT_EXIT_CODE_2,
    parameter int         MAX_TRIES   = DEFAULT_MAX_TRIES
) (
    input logic                       clk,
    input logic                       reset,
    parking_exit_controller_if.slave  bus
);

    localparam int WW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int TW = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);

    state_t          state_reg, state_next;
    logic [WW-1:0]   wait_reg, wait_next;
    logic [TW-1:0]   tries_reg, tries_next, tries_inc;
    logic            blink_reg, blink_next;
    panel_t          panel_reg;
    logic            code_ok;
    logic            exit_dec;
    logic [7:0]      count;
    logic            count_full;

    assign code_ok   = (bus.pass_1 == EXIT_CODE_1) && (bus.pass_2 == EXIT_CODE_2);
    assign tries_inc = tries_reg + TW'(1);

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        tries_next = tries_reg;
        exit_dec   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.sensor_exit_approach && (count != 8'd0))
                    state_next = ST_WAIT_PASS;
            end
            ST_WAIT_PASS: begin
                if (wait_reg < WW'(WAIT_CYCLES)) begin
                    wait_next = wait_reg + WW'(1);
                end else if (code_ok) begin
                    state_next = ST_OPEN;
                    wait_next  = '0;
                    tries_next = '0;
                end else begin
                    wait_next  = '0;
                    tries_next = tries_inc;
                    state_next = (tries_inc >= TW'(MAX_TRIES)) ? ST_LOCKED : ST_WRONG_PASS;
                end
            end
            ST_WRONG_PASS: begin
                // A correct code is accepted any cycle; a wrong one only counts once per period
                if (code_ok) begin
                    state_next = ST_OPEN;
                    wait_next  = '0;
                    tries_next = '0;
                end else if (wait_reg >= WW'(WAIT_CYCLES - 1)) begin
                    wait_next  = '0;
                    tries_next = tries_inc;
                    if (tries_inc >= TW'(MAX_TRIES))
                        state_next = ST_LOCKED;
                end else begin
                    wait_next = wait_reg + WW'(1);
                end
            end
            ST_OPEN: begin
                if (bus.sensor_exit_clear && bus.sensor_exit_approach) begin
                    state_next = ST_BLOCKED;
                end else if (bus.sensor_exit_clear) begin
                    exit_dec   = 1'b1;
                    state_next = ST_IDLE;
                    wait_next  = '0;
                    tries_next = '0;
                end
            end
            ST_BLOCKED: begin
                if (code_ok) begin
                    state_next = ST_OPEN;
                    wait_next  = '0;
                    tries_next = '0;
                end
            end
            ST_LOCKED: begin
                if (bus.supervisor_clear) begin
                    state_next = ST_IDLE;
                    wait_next  = '0;
                    tries_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                wait_next  = '0;
                tries_next = '0;
            end
        endcase
        blink_next = blinks_in(state_next) ? ~blink_reg : 1'b0;
    end

    // Panel is decoded from the next state so it is valid in the cycle the state is entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            wait_reg  <= '0;
            tries_reg <= '0;
            blink_reg <= 1'b0;
            panel_reg <= decode_panel(ST_IDLE, 1'b0);
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            tries_reg <= tries_next;
            blink_reg <= blink_next;
            panel_reg <= decode_panel(state_next, blink_next);
        end
    end

    parking_occupancy_counter #(
        .CAPACITY (CAPACITY)
    ) u_occupancy (
        .clk       (clk),
        .reset     (reset),
        .inc       (bus.car_entered),
        .dec       (exit_dec),
        .car_count (count),
        .full      (count_full)
    );

    assign bus.gate_open = panel_reg.gate_open;
    assign bus.green_led = panel_reg.green_led;
    assign bus.red_led   = panel_reg.red_led;
    assign bus.hex_1     = panel_reg.hex_1;
    assign bus.hex_2     = panel_reg.hex_2;
    assign bus.car_count = count;
    assign bus.full      = count_full;

endmodule
